// File: rtl/ret_stack_ctrl_if.sv
// rtl/ret_stack_ctrl_if.sv - fetch-buffer instruction handshake into ret_stack_ctrl
interface ret_stack_ctrl_if;
    logic        IN_instValid;
    logic        OUT_instReady;
    logic [31:0] IN_instr;
    logic [30:0] IN_pc;

    modport master (
        output IN_instValid,
        output IN_instr,
        output IN_pc,
        input  OUT_instReady
    );

    modport slave (
        input  IN_instValid,
        input  IN_instr,
        input  IN_pc,
        output OUT_instReady
    );
endinterface

// File: rtl/ret_stack_ctrl.sv
// rtl/ret_stack_ctrl.sv - decode-side call/return classifier driving the return address stack
// Optional compressed-instruction decode is enabled by defining RVC_EN.
module ret_stack_ctrl #(
    parameter int NUM_ENTRIES = 8
) (
    input  logic               clk,
    input  logic               rst,
    ret_stack_ctrl_if.slave    fetch,
    input  logic               IN_flush,
    output logic               OUT_push,
    output logic [30:0]        OUT_pushData,
    output logic               OUT_pop,
    input  logic               IN_stackValid,
    input  logic [30:0]        IN_stackData,
    output logic               OUT_retValid,
    output logic               OUT_retHit,
    output logic [30:0]        OUT_retTarget
);

    typedef enum logic [1:0] {OP_NONE, OP_PUSH, OP_POP, OP_SWAP} op_e;
    typedef enum logic [0:0] {S_IDLE, S_SWAP2} state_e;

    localparam logic [6:0] OPC_JAL  = 7'b1101111;
    localparam logic [6:0] OPC_JALR = 7'b1100111;

    // The stack depth is owned by the stack itself; nothing here depends on it.
    if (NUM_ENTRIES < 1) begin : g_bad_depth
    end

    state_e      r_state;
    logic        r_stPop;
    logic [30:0] r_stLink;
    logic        r_push;
    logic [30:0] r_pushData;
    logic        r_retValid;
    logic        r_retHit;
    logic [30:0] r_retTarget;

    op_e         w_op;
    logic [30:0] w_link;
    logic        w_ready;
    logic        w_accept;
    logic [4:0]  w_rd;
    logic [4:0]  w_rs1;
    logic        w_unused_instr;

    function automatic logic is_link(input logic [4:0] r);
        return (r == 5'd1) || (r == 5'd5);
    endfunction

    assign w_rd           = fetch.IN_instr[11:7];
    assign w_rs1          = fetch.IN_instr[19:15];
    assign w_unused_instr = ^fetch.IN_instr[31:20];

    always_comb begin
        w_op   = OP_NONE;
        w_link = fetch.IN_pc + 31'd2;
        if (fetch.IN_instr[1:0] == 2'b11) begin
            if (fetch.IN_instr[6:0] == OPC_JAL && is_link(w_rd)) begin
                w_op = OP_PUSH;
            end else if (fetch.IN_instr[6:0] == OPC_JALR && fetch.IN_instr[14:12] == 3'b000) begin
                if (is_link(w_rd) && !is_link(w_rs1))
                    w_op = OP_PUSH;
                else if (!is_link(w_rd) && is_link(w_rs1))
                    w_op = OP_POP;
                else if (is_link(w_rd) && is_link(w_rs1))
                    w_op = (w_rd == w_rs1) ? OP_PUSH : OP_SWAP;
            end
        end
`ifdef RVC_EN
        else begin
            // Compressed forms: rs1 sits in [11:7], rs2 in [6:2]; c.jalr always links x1.
            w_link = fetch.IN_pc + 31'd1;
            if (fetch.IN_instr[15:13] == 3'b001 && fetch.IN_instr[1:0] == 2'b01) begin
                w_op = OP_PUSH;
            end else if (fetch.IN_instr[1:0] == 2'b10 && fetch.IN_instr[6:2] == 5'd0
                         && w_rd != 5'd0) begin
                if (fetch.IN_instr[15:12] == 4'b1001)
                    w_op = (w_rd == 5'd5) ? OP_SWAP : OP_PUSH;
                else if (fetch.IN_instr[15:12] == 4'b1000 && is_link(w_rd))
                    w_op = OP_POP;
            end
        end
`endif
    end

    assign w_ready             = (r_state == S_IDLE) && !rst && !IN_flush;
    assign w_accept            = fetch.IN_instValid && w_ready;
    assign fetch.OUT_instReady = w_ready;

    // A pending pop is only issued when the stack actually has an entry.
    assign OUT_pop       = r_stPop && IN_stackValid;
    assign OUT_push      = r_push;
    assign OUT_pushData  = r_pushData;
    assign OUT_retValid  = r_retValid;
    assign OUT_retHit    = r_retHit;
    assign OUT_retTarget = r_retTarget;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_stPop     <= 1'b0;
            r_stLink    <= '0;
            r_push      <= 1'b0;
            r_pushData  <= '0;
            r_retValid  <= 1'b0;
            r_retHit    <= 1'b0;
            r_retTarget <= '0;
        end else begin
            r_push      <= 1'b0;
            r_pushData  <= '0;
            r_stPop     <= 1'b0;
            r_retValid  <= 1'b0;
            r_retHit    <= 1'b0;
            r_retTarget <= '0;
            if (IN_flush) begin
                r_state <= S_IDLE;
            end else begin
                if (r_stPop) begin
                    r_retValid  <= 1'b1;
                    r_retHit    <= IN_stackValid;
                    r_retTarget <= IN_stackValid ? IN_stackData : '0;
                end
                case (r_state)
                    S_IDLE: begin
                        if (w_accept) begin
                            case (w_op)
                                OP_PUSH: begin
                                    r_push     <= 1'b1;
                                    r_pushData <= w_link;
                                end
                                OP_POP: r_stPop <= 1'b1;
                                OP_SWAP: begin
                                    r_stPop  <= 1'b1;
                                    r_stLink <= w_link;
                                    r_state  <= S_SWAP2;
                                end
                                default: ;
                            endcase
                        end
                    end
                    S_SWAP2: begin
                        r_push     <= 1'b1;
                        r_pushData <= r_stLink;
                        r_state    <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
